// File: rtl/rule_sched_pkg.sv
// Shared helpers for the rule scheduler: pointer width, popcount and
// conflict-matrix indexing.
package rule_sched_pkg;

    localparam int MAX_RULES = 64;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [31:0] popcount(input logic [MAX_RULES-1:0] v);
        logic [31:0] c;
        c = 32'd0;
        for (int i = 0; i < MAX_RULES; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

    function automatic int cidx(input int i, input int j, input int n);
        return i * n + j;
    endfunction

endpackage

// File: rtl/rule_scheduler_if.sv
// Rule guard/enable vectors plus the debug control and status signals of the
// rule scheduler.
interface rule_scheduler_if #(
    parameter int RULE_COUNT = 8
);
    logic [RULE_COUNT-1:0] rule_ready;
    logic [RULE_COUNT-1:0] rule_enable;
    logic                  cfg_mask__ENA;
    logic [RULE_COUNT-1:0] cfg_mask_v;
    logic                  cfg_mask__RDY;
    logic                  cfg_run__ENA;
    logic                  cfg_run_v;
    logic                  step__ENA;
    logic                  step__RDY;
    logic [31:0]           fire_count;
    logic                  idle;

    modport master (
        output rule_ready, cfg_mask__ENA, cfg_mask_v, cfg_run__ENA, cfg_run_v, step__ENA,
        input  rule_enable, cfg_mask__RDY, step__RDY, fire_count, idle
    );

    modport slave (
        input  rule_ready, cfg_mask__ENA, cfg_mask_v, cfg_run__ENA, cfg_run_v, step__ENA,
        output rule_enable, cfg_mask__RDY, step__RDY, fire_count, idle
    );
endinterface

// File: rtl/rule_sched_pick.sv
// Combinational greedy picker: scans from ptr with wrap-around and grants every
// eligible rule that does not conflict with a rule already granted.
module rule_sched_pick
    import rule_sched_pkg::*;
#(
    parameter int                               RULE_COUNT = 8,
    parameter logic [RULE_COUNT*RULE_COUNT-1:0] CONFLICT   = '0,
    parameter int                               PTR_W      = ptr_width(RULE_COUNT)
) (
    input  logic [RULE_COUNT-1:0] elig,
    input  logic [PTR_W-1:0]      ptr,
    output logic [RULE_COUNT-1:0] grant,
    output logic [PTR_W-1:0]      first_idx
);

    logic found_s;
    logic blocked_s;

    // Rotating scan; the conflict matrix is treated as symmetric
    always_comb begin
        grant     = '0;
        first_idx = '0;
        found_s   = 1'b0;
        blocked_s = 1'b0;
        for (int s = 0; s < RULE_COUNT; s++) begin
            for (int k = 0; k < RULE_COUNT; k++) begin
                if (((int'(ptr) + s) % RULE_COUNT) == k) begin
                    blocked_s = 1'b0;
                    for (int j = 0; j < RULE_COUNT; j++) begin
                        if (grant[j] && (j != k) &&
                            (CONFLICT[cidx(k, j, RULE_COUNT)] || CONFLICT[cidx(j, k, RULE_COUNT)])) begin
                            blocked_s = 1'b1;
                        end else begin
                            blocked_s = blocked_s;
                        end
                    end
                    if (elig[k] && !blocked_s) begin
                        grant[k] = 1'b1;
                        if (!found_s) begin
                            first_idx = PTR_W'(k);
                            found_s   = 1'b1;
                        end else begin
                            found_s   = found_s;
                        end
                    end else begin
                        grant[k] = grant[k];
                    end
                end else begin
                    blocked_s = blocked_s;
                end
            end
        end
    end

endmodule

// File: rtl/rule_scheduler.sv
// Central rule scheduler: fires a maximal conflict-free set of ready rules per
// cycle with rotating priority, plus run/step control, rule mask and fire counter.
module rule_scheduler
    import rule_sched_pkg::*;
#(
    parameter int                               RULE_COUNT   = 8,
    parameter logic [RULE_COUNT*RULE_COUNT-1:0] CONFLICT     = '0,
    parameter logic                             RUN_AT_RESET = 1'b1
) (
    input logic             CLK,
    input logic             RST,
    rule_scheduler_if.slave bus
);

    localparam int               PTR_W    = ptr_width(RULE_COUNT);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(RULE_COUNT - 1);

    logic [PTR_W-1:0]      ptr_r;
    logic [RULE_COUNT-1:0] mask_r;
    logic                  run_r;
    logic                  step_pending_r;
    logic [31:0]           fire_count_r;

    logic [RULE_COUNT-1:0] elig_s;
    logic [RULE_COUNT-1:0] grant_s;
    logic [RULE_COUNT-1:0] enable_s;
    logic [PTR_W-1:0]      first_idx_s;
    logic                  active_s;
    logic                  any_grant_s;
    logic                  step_rdy_s;
    logic [32:0]           fire_sum_s;

    assign elig_s      = bus.rule_ready & mask_r;
    assign active_s    = run_r | step_pending_r;
    assign step_rdy_s  = ~run_r & ~step_pending_r;
    assign any_grant_s = |enable_s;
    assign fire_sum_s  = {1'b0, fire_count_r} + {1'b0, popcount(MAX_RULES'(enable_s))};

    rule_sched_pick #(
        .RULE_COUNT (RULE_COUNT),
        .CONFLICT   (CONFLICT),
        .PTR_W      (PTR_W)
    ) u_pick (
        .elig      (elig_s),
        .ptr       (ptr_r),
        .grant     (grant_s),
        .first_idx (first_idx_s)
    );

    // Reset forces all enables low; a halted scheduler fires nothing
    always_comb begin
        enable_s = '0;
        if (RST) begin
            enable_s = '0;
        end else if (active_s) begin
            enable_s = grant_s;
        end else begin
            enable_s = '0;
        end
    end

    assign bus.rule_enable   = enable_s;
    assign bus.cfg_mask__RDY = 1'b1;
    assign bus.step__RDY     = step_rdy_s;
    assign bus.fire_count    = fire_count_r;
    assign bus.idle          = (elig_s == '0);

    // Priority pointer, mask, run/step state and saturating fire counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_r          <= '0;
            mask_r         <= '1;
            run_r          <= RUN_AT_RESET;
            step_pending_r <= 1'b0;
            fire_count_r   <= 32'd0;
        end else begin
            if (any_grant_s) begin
                ptr_r <= (first_idx_s == LAST_IDX) ? '0 : first_idx_s + PTR_W'(1);
            end else begin
                ptr_r <= ptr_r;
            end

            if (bus.cfg_mask__ENA) begin
                mask_r <= bus.cfg_mask_v;
            end else begin
                mask_r <= mask_r;
            end

            if (bus.cfg_run__ENA) begin
                run_r <= bus.cfg_run_v;
            end else begin
                run_r <= run_r;
            end

            // cfg_run wins over a simultaneous step request
            if (bus.cfg_run__ENA && bus.cfg_run_v) begin
                step_pending_r <= 1'b0;
            end else if (!run_r && step_pending_r && any_grant_s) begin
                step_pending_r <= 1'b0;
            end else if (bus.step__ENA && step_rdy_s && !bus.cfg_run__ENA) begin
                step_pending_r <= 1'b1;
            end else begin
                step_pending_r <= step_pending_r;
            end

            fire_count_r <= fire_sum_s[32] ? 32'hFFFF_FFFF : fire_sum_s[31:0];
        end
    end

endmodule

// File: tb/tb_rule_scheduler.sv
// Self-checking bench for rule_scheduler (4 rules, rules 0 and 1 conflict):
// directed scenarios with literal expectations, then randomized traffic.
module tb_rule_scheduler;

    localparam int N = 4;

    logic CLK;
    logic RST;

    rule_scheduler_if #(.RULE_COUNT(N)) bus ();

    rule_scheduler #(
        .RULE_COUNT   (N),
        .CONFLICT     (16'h0002),
        .RUN_AT_RESET (1'b1)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model state
    int          m_ptr;
    logic [3:0]  m_mask;
    bit          m_run;
    bit          m_step;
    logic [31:0] m_count;
    bit          m_valid = 1'b0;
    int          granted[$];

    function automatic bit conf(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0);
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model past the next edge
    always @(negedge CLK) begin : model
        logic [3:0]  elig;
        logic [3:0]  exp_en;
        logic [32:0] sum;
        bit          ok;
        bit          r0;
        bit          s0;
        bit          fired;
        int          k;
        elig   = bus.rule_ready & m_mask;
        exp_en = 4'b0000;
        granted.delete();
        if (!RST && m_valid && (m_run || m_step)) begin
            for (int s = 0; s < N; s++) begin
                k  = (m_ptr + s) % N;
                ok = elig[k];
                foreach (granted[g]) begin
                    if (conf(k, granted[g])) ok = 1'b0;
                end
                if (ok) begin
                    granted.push_back(k);
                    exp_en[k] = 1'b1;
                end
            end
        end
        chk("model_enable", 32'(bus.rule_enable), 32'(exp_en));
        if (m_valid) begin
            chk("model_idle", 32'(bus.idle), 32'(elig == 4'b0000));
            chk("model_step_rdy", 32'(bus.step__RDY), 32'(!m_run && !m_step));
            chk("model_fire_count", bus.fire_count, m_count);
        end
        if (RST) begin
            m_ptr   = 0;
            m_mask  = 4'b1111;
            m_run   = 1'b1;
            m_step  = 1'b0;
            m_count = 32'd0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            r0    = m_run;
            s0    = m_step;
            fired = (granted.size() > 0);
            if (fired) m_ptr = (granted[0] + 1) % N;
            if (bus.cfg_mask__ENA) m_mask = bus.cfg_mask_v;
            if (bus.cfg_run__ENA) begin
                m_run = bus.cfg_run_v;
                if (bus.cfg_run_v || (s0 && fired)) m_step = 1'b0;
            end else if (bus.step__ENA && !r0 && !s0) begin
                m_step = 1'b1;
            end else if (!r0 && s0 && fired) begin
                m_step = 1'b0;
            end
            sum     = {1'b0, m_count} + 33'($countones(exp_en));
            m_count = (sum > 33'h0_FFFF_FFFF) ? 32'hFFFF_FFFF : sum[31:0];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
        bus.cfg_mask__ENA = 1'b0;
        bus.cfg_run__ENA  = 1'b0;
        bus.step__ENA     = 1'b0;
    endtask

    logic [3:0] fair_seq [4];

    initial begin
        fair_seq[0] = 4'b0001;
        fair_seq[1] = 4'b0010;
        fair_seq[2] = 4'b0001;
        fair_seq[3] = 4'b0010;

        RST               = 1'b1;
        bus.rule_ready    = 4'b1111;
        bus.cfg_mask__ENA = 1'b0;
        bus.cfg_mask_v    = 4'b0000;
        bus.cfg_run__ENA  = 1'b0;
        bus.cfg_run_v     = 1'b0;
        bus.step__ENA     = 1'b0;

        // Reset held with all guards ready
        repeat (2) begin
            @(negedge CLK);
            chk("rst_enable", 32'(bus.rule_enable), 32'd0);
        end
        chk("rst_fire_count", bus.fire_count, 32'd0);
        tick();
        RST            = 1'b0;
        bus.rule_ready = 4'b0000;
        @(negedge CLK);
        chk("rst_ptr", 32'(dut.ptr_r), 32'd0);
        chk("rst_step_rdy", 32'(bus.step__RDY), 32'd0);
        tick();

        // Fairness under conflict
        bus.rule_ready = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            chk("fair_enable", 32'(bus.rule_enable), 32'(fair_seq[i]));
            tick();
        end
        bus.rule_ready = 4'b0000;
        @(negedge CLK);
        chk("fair_count", bus.fire_count, 32'd4);
        tick();

        // Non-conflicting parallel fire
        bus.rule_ready = 4'b1101;
        @(negedge CLK);
        chk("par_enable", 32'(bus.rule_enable), 32'h0000_000D);
        tick();
        bus.rule_ready = 4'b0000;
        @(negedge CLK);
        chk("par_count", bus.fire_count, 32'd7);
        tick();

        // Mask write: old mask still applies in the write cycle
        bus.cfg_mask__ENA = 1'b1;
        bus.cfg_mask_v    = 4'b1110;
        bus.rule_ready    = 4'b0001;
        @(negedge CLK);
        chk("mask_wr_enable", 32'(bus.rule_enable), 32'd1);
        tick();
        @(negedge CLK);
        chk("mask_enable", 32'(bus.rule_enable), 32'd0);
        chk("mask_idle", 32'(bus.idle), 32'd1);
        tick();
        bus.rule_ready    = 4'b0000;
        bus.cfg_mask__ENA = 1'b1;
        bus.cfg_mask_v    = 4'b1111;
        @(negedge CLK);
        tick();

        // Halt, then single-step
        bus.cfg_run__ENA = 1'b1;
        bus.cfg_run_v    = 1'b0;
        @(negedge CLK);
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.step__ENA = 1'b1;
            @(negedge CLK);
            chk("step_rdy_wait", 32'(bus.step__RDY), (i == 0) ? 32'd1 : 32'd0);
            chk("step_wait_enable", 32'(bus.rule_enable), 32'd0);
            tick();
        end
        bus.rule_ready = 4'b0100;
        @(negedge CLK);
        chk("step_enable", 32'(bus.rule_enable), 32'd4);
        tick();
        @(negedge CLK);
        chk("step_done_enable", 32'(bus.rule_enable), 32'd0);
        chk("step_done_rdy", 32'(bus.step__RDY), 32'd1);
        tick();
        bus.rule_ready   = 4'b0000;
        bus.cfg_run__ENA = 1'b1;
        bus.cfg_run_v    = 1'b1;
        @(negedge CLK);
        tick();

        // Saturation and pointer wrap
        @(negedge CLK);
        #1;
        force dut.fire_count_r = 32'hFFFF_FFFE;
        m_count = 32'hFFFF_FFFE;
        @(posedge CLK);
        #1;
        release dut.fire_count_r;
        bus.rule_ready = 4'b1101;
        @(negedge CLK);
        chk("sat_enable", 32'(bus.rule_enable), 32'h0000_000D);
        chk("sat_pre_count", bus.fire_count, 32'hFFFF_FFFE);
        tick();
        bus.rule_ready = 4'b1000;
        @(negedge CLK);
        chk("sat_count", bus.fire_count, 32'hFFFF_FFFF);
        chk("wrap_enable", 32'(bus.rule_enable), 32'd8);
        tick();
        bus.rule_ready = 4'b0000;
        @(negedge CLK);
        chk("wrap_ptr", 32'(dut.ptr_r), 32'd0);
        chk("sat_hold", bus.fire_count, 32'hFFFF_FFFF);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            bus.rule_ready    = 4'($urandom);
            bus.cfg_mask__ENA = ($urandom_range(0, 9) == 0);
            bus.cfg_mask_v    = 4'($urandom);
            bus.cfg_run__ENA  = ($urandom_range(0, 11) == 0);
            bus.cfg_run_v     = 1'($urandom);
            bus.step__ENA     = ($urandom_range(0, 3) == 0);
            RST               = ($urandom_range(0, 99) == 0);
            @(negedge CLK);
            tick();
        end
        RST = 1'b0;
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
